// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run controller for the 5-stage MIPS pipeline.
// Owns the pipeline enable/reset, sequences clear, free-run, single-step,
// stop, PC breakpoint and halt-and-drain, and counts pipeline advances.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | pipeline frozen, waiting for a command
//   CLEAR   | pipe_rst held for CLEAR_CYCLES cycles, then IDLE
//   RUN     | free-run until halt fetch, STOP or breakpoint
//   STEP    | exactly one advance, then IDLE (or DRAIN on halt fetch)
//   DRAIN   | DRAIN_CYCLES bubble advances to flush ID..WB
//   HALTED  | program finished; only CLEAR or SET_BP have an effect
module pipeline_run_ctrl #(
  parameter logic [31:0] HALT_OPCODE  = 32'hFFFF_FFFF,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_op,
  input  logic [31:0]          cmd_arg,
  output logic                 cmd_ready,
  input  logic [31:0]          if_pc,
  input  logic [31:0]          if_instruction,
  output logic                 pipe_ena,
  output logic                 pipe_rst,
  output logic                 fetch_bubble,
  output logic [2:0]           state,
  output logic                 halted,
  output logic                 done_pulse,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_STOP   = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5;

  // One shared down-counter serves both CLEAR and DRAIN; size it for the larger.
  localparam int unsigned CTR_MAX = (DRAIN_CYCLES > CLEAR_CYCLES) ? DRAIN_CYCLES : CLEAR_CYCLES;
  localparam int unsigned CTR_W   = (CTR_MAX < 2) ? 1 : $clog2(CTR_MAX + 1);
  localparam logic [CTR_W-1:0] DRAIN_LOAD = CTR_W'(DRAIN_CYCLES);
  localparam logic [CTR_W-1:0] CLEAR_LOAD = CTR_W'(CLEAR_CYCLES);
  localparam logic [CTR_W-1:0] CTR_ONE    = CTR_W'(1);

  state_t             state_r, state_nxt;
  logic [CTR_W-1:0]   ctr_r, ctr_nxt;
  logic [31:0]        bp_pc_r, bp_pc_nxt;
  logic               bp_valid_r, bp_valid_nxt;
  logic               done_nxt;
  logic               cnt_clr;
  logic               accepted;
  logic               halt_hit;

  // State, counter, breakpoint and done-pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_CLEAR;
      ctr_r      <= CLEAR_LOAD;
      bp_pc_r    <= '0;
      bp_valid_r <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      ctr_r      <= ctr_nxt;
      bp_pc_r    <= bp_pc_nxt;
      bp_valid_r <= bp_valid_nxt;
      done_pulse <= done_nxt;
    end
  end

  // Next-state logic plus outputs decoded from the registered state only.
  always_comb begin
    state_nxt    = state_r;
    ctr_nxt      = ctr_r;
    bp_pc_nxt    = bp_pc_r;
    bp_valid_nxt = bp_valid_r;
    cnt_clr      = 1'b0;
    pipe_ena     = 1'b0;
    pipe_rst     = 1'b0;
    fetch_bubble = 1'b0;
    halted       = 1'b0;
    cmd_ready    = 1'b1;

    case (state_r)
      ST_CLEAR:  begin pipe_rst = 1'b1; cmd_ready = 1'b0; end
      ST_RUN:    pipe_ena = 1'b1;
      ST_STEP:   pipe_ena = 1'b1;
      ST_DRAIN:  begin pipe_ena = 1'b1; fetch_bubble = 1'b1; cmd_ready = 1'b0; end
      ST_HALTED: halted = 1'b1;
      default:   ;
    endcase

    accepted = cmd_valid && cmd_ready;
    halt_hit = (if_instruction == HALT_OPCODE);

    case (state_r)
      ST_IDLE: begin
        if (accepted) begin
          case (cmd_op)
            OP_RUN:    state_nxt = ST_RUN;
            OP_STEP:   state_nxt = ST_STEP;
            OP_CLEAR:  begin state_nxt = ST_CLEAR; ctr_nxt = CLEAR_LOAD; cnt_clr = 1'b1; end
            OP_SET_BP: begin bp_pc_nxt = cmd_arg; bp_valid_nxt = 1'b1; end
            default:   ;
          endcase
        end
      end
      ST_CLEAR: begin
        if (ctr_r <= CTR_ONE) begin
          state_nxt = ST_IDLE;
          ctr_nxt   = '0;
        end else begin
          ctr_nxt = ctr_r - CTR_ONE;
        end
      end
      ST_RUN: begin
        // Halt fetch wins over STOP, which wins over the breakpoint.
        if (halt_hit) begin
          state_nxt = ST_DRAIN;
          ctr_nxt   = DRAIN_LOAD;
        end else if (accepted && cmd_op == OP_STOP) begin
          state_nxt = ST_IDLE;
        end else if (bp_valid_r && if_pc == bp_pc_r) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (halt_hit) begin
          state_nxt = ST_DRAIN;
          ctr_nxt   = DRAIN_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (ctr_r <= CTR_ONE) begin
          state_nxt = ST_HALTED;
          ctr_nxt   = '0;
        end else begin
          ctr_nxt = ctr_r - CTR_ONE;
        end
      end
      ST_HALTED: begin
        if (accepted && cmd_op == OP_CLEAR) begin
          state_nxt = ST_CLEAR;
          ctr_nxt   = CLEAR_LOAD;
          cnt_clr   = 1'b1;
        end else if (accepted && cmd_op == OP_SET_BP) begin
          bp_pc_nxt    = cmd_arg;
          bp_valid_nxt = 1'b1;
        end
      end
      default: begin
        // Unused encodings recover through a clean pipeline clear.
        state_nxt = ST_CLEAR;
        ctr_nxt   = CLEAR_LOAD;
      end
    endcase

    done_nxt = (state_nxt == ST_HALTED) && (state_r != ST_HALTED);
  end

  // Saturating advance counter, zeroed on entry to CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (cnt_clr) begin
      cycle_count <= '0;
    end else if (pipe_ena && cycle_count != '1) begin
      cycle_count <= cycle_count + CNT_WIDTH'(1);
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl with a scoreboard queue of expected
// values and a minimal IF-stage model (PC advances by 4 per pipe_ena edge).
module tb_pipeline_run_ctrl;

  localparam logic [2:0] OP_RUN    = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_STOP   = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_SET_BP = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_arg = 32'd0;
  logic        cmd_ready;
  logic [31:0] pc = 32'd0;
  logic [31:0] halt_addr = 32'hFFFF_FFF0;
  logic [31:0] if_instruction;
  logic        pipe_ena, pipe_rst, fetch_bubble, halted, done_pulse;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  assign if_instruction = (pc == halt_addr) ? 32'hFFFF_FFFF : 32'h0000_0000;

  pipeline_run_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_op         (cmd_op),
    .cmd_arg        (cmd_arg),
    .cmd_ready      (cmd_ready),
    .if_pc          (pc),
    .if_instruction (if_instruction),
    .pipe_ena       (pipe_ena),
    .pipe_rst       (pipe_rst),
    .fetch_bubble   (fetch_bubble),
    .state          (state),
    .halted         (halted),
    .done_pulse     (done_pulse),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp_v;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      exp_v = exp_q.pop_front();
      tag   = tag_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
    end
  endtask

  // One clock; the IF model advances if pipe_ena was high going into the edge.
  task automatic tick();
    logic ena;
    ena = pipe_ena;
    @(posedge clk);
    #1;
    if (ena) pc = pc + 32'd4;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] arg);
    int b;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    b = 0;
    while (!cmd_ready && b < 20) begin
      tick();
      b++;
    end
    if (!cmd_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout observed ready=0 expected ready=1");
    end else begin
      tick();
    end
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
  endtask

  task automatic wait_state(input logic [2:0] s);
    int b;
    b = 0;
    while (state !== s && b < 50) begin
      tick();
      b++;
    end
    expect_val("wait_state", 32'(s));
    check(32'(state));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bubbles, ready_bad;

    // Reset held: CLEAR with everything quiet except pipe_rst.
    repeat (3) @(posedge clk);
    #1;
    expect_val("rst_state", 32'd1);
    expect_val("rst_pipe_rst", 32'd1);
    expect_val("rst_pipe_ena", 32'd0);
    expect_val("rst_cmd_ready", 32'd0);
    expect_val("rst_halted", 32'd0);
    expect_val("rst_done", 32'd0);
    expect_val("rst_bubble", 32'd0);
    expect_val("rst_count", 32'd0);
    check(32'(state));
    check(32'(pipe_rst));
    check(32'(pipe_ena));
    check(32'(cmd_ready));
    check(32'(halted));
    check(32'(done_pulse));
    check(32'(fetch_bubble));
    check(cycle_count);

    // Release: two CLEAR cycles then IDLE.
    reset = 1'b1;
    expect_val("clear_cycles", 32'd2);
    expect_val("idle_state", 32'd0);
    expect_val("idle_pipe_ena", 32'd0);
    expect_val("idle_count", 32'd0);
    expect_val("idle_cmd_ready", 32'd1);
    n = 0;
    while (pipe_rst && n < 10) begin
      n++;
      tick();
    end
    check(32'(n));
    check(32'(state));
    check(32'(pipe_ena));
    check(cycle_count);
    check(32'(cmd_ready));

    // RUN for 10 advances, then STOP.
    pc = 32'd0;
    expect_val("run_ena_on", 32'd1);
    send(OP_RUN, 32'd0);
    check(32'(pipe_ena));
    expect_val("run_ena_before_stop", 32'd1);
    repeat (10) tick();
    check(32'(pipe_ena));
    expect_val("stop_ena_off", 32'd0);
    expect_val("stop_count", 32'd11);
    expect_val("stop_state", 32'd0);
    expect_val("stop_pc", 32'h2C);
    send(OP_STOP, 32'd0);
    check(32'(pipe_ena));
    check(cycle_count);
    check(32'(state));
    check(pc);

    // Breakpoint at 0x20, run from PC 0.
    send(OP_CLEAR, 32'd0);
    wait_state(3'd0);
    expect_val("clear_count", 32'd0);
    check(cycle_count);
    pc = 32'd0;
    send(OP_SET_BP, 32'h20);
    expect_val("bp_count", 32'd9);
    expect_val("bp_state", 32'd0);
    expect_val("bp_pc", 32'h24);
    send(OP_RUN, 32'd0);
    n = 0;
    while (pipe_ena && n < 40) begin
      tick();
      n++;
    end
    check(cycle_count);
    check(32'(state));
    check(pc);
    expect_val("bp_resume_ena", 32'd1);
    expect_val("bp_resume_count", 32'd13);
    expect_val("bp_resume_state", 32'd0);
    send(OP_RUN, 32'd0);
    repeat (3) tick();
    check(32'(pipe_ena));
    send(OP_STOP, 32'd0);
    check(cycle_count);
    check(32'(state));

    // Three STEPs, then a STEP sitting on the breakpoint address.
    send(OP_CLEAR, 32'd0);
    wait_state(3'd0);
    pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      expect_val("step_ena_hi", 32'd1);
      expect_val("step_ena_lo", 32'd0);
      send(OP_STEP, 32'd0);
      check(32'(pipe_ena));
      tick();
      check(32'(pipe_ena));
    end
    expect_val("step_count", 32'd3);
    expect_val("step_pc", 32'd12);
    check(cycle_count);
    check(pc);
    pc = 32'h20;
    expect_val("step_bp_state", 32'd3);
    expect_val("step_bp_ena_lo", 32'd0);
    expect_val("step_bp_idle", 32'd0);
    expect_val("step_bp_count", 32'd4);
    expect_val("step_bp_pc", 32'h24);
    send(OP_STEP, 32'd0);
    check(32'(state));
    tick();
    check(32'(pipe_ena));
    check(32'(state));
    check(cycle_count);
    check(pc);

    // Halt fetch at 0x10 coinciding with STOP: DRAIN then HALTED.
    send(OP_CLEAR, 32'd0);
    wait_state(3'd0);
    pc = 32'd0;
    halt_addr = 32'h10;
    send(OP_RUN, 32'd0);
    repeat (4) tick();
    expect_val("halt_state_drain", 32'd4);
    expect_val("halt_bubble", 32'd1);
    expect_val("halt_ready", 32'd0);
    send(OP_STOP, 32'd0);
    check(32'(state));
    check(32'(fetch_bubble));
    check(32'(cmd_ready));
    expect_val("drain_bubbles", 32'd4);
    expect_val("drain_ready_hi", 32'd0);
    expect_val("halted_flag", 32'd1);
    expect_val("done_first", 32'd1);
    expect_val("halted_ena", 32'd0);
    expect_val("halted_count", 32'd9);
    expect_val("done_second", 32'd0);
    expect_val("halted_still", 32'd1);
    bubbles = 0;
    ready_bad = 0;
    n = 0;
    while (!halted && n < 20) begin
      if (fetch_bubble) bubbles++;
      if (cmd_ready) ready_bad++;
      tick();
      n++;
    end
    check(32'(bubbles));
    check(32'(ready_bad));
    check(32'(halted));
    check(32'(done_pulse));
    check(32'(pipe_ena));
    check(cycle_count);
    tick();
    check(32'(done_pulse));
    check(32'(halted));
    expect_val("halted_ignores_run", 32'd5);
    expect_val("halted_ignores_ena", 32'd0);
    send(OP_RUN, 32'd0);
    check(32'(state));
    check(32'(pipe_ena));

    // Async reset in the second DRAIN cycle.
    send(OP_CLEAR, 32'd0);
    wait_state(3'd0);
    pc = 32'd0;
    halt_addr = 32'h8;
    send(OP_RUN, 32'd0);
    repeat (4) tick();
    expect_val("drain2_state", 32'd4);
    expect_val("drain2_ena", 32'd1);
    check(32'(state));
    check(32'(pipe_ena));
    expect_val("async_ena", 32'd0);
    expect_val("async_state", 32'd1);
    expect_val("async_pipe_rst", 32'd1);
    expect_val("async_bubble", 32'd0);
    #2 reset = 1'b0;
    #1;
    check(32'(pipe_ena));
    check(32'(state));
    check(32'(pipe_rst));
    check(32'(fetch_bubble));
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_state(3'd0);
    expect_val("post_reset_halted", 32'd0);
    expect_val("post_reset_count", 32'd0);
    check(32'(halted));
    check(cycle_count);
    // Breakpoint was cleared by reset: running across 0x20 must not stop.
    pc = 32'h18;
    halt_addr = 32'hFFFF_FFF0;
    expect_val("no_bp_ena", 32'd1);
    expect_val("no_bp_state", 32'd2);
    expect_val("no_bp_stop", 32'd0);
    send(OP_RUN, 32'd0);
    repeat (4) tick();
    check(32'(pipe_ena));
    check(32'(state));
    send(OP_STOP, 32'd0);
    check(32'(state));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
